pipo: RTL and testbench

PIPO -- requirements
Module: pipo

---
 rtl/pipo_pkg.sv | 16 +
 rtl/pipo.sv | 96 +++++++++
 tb/tb_pipo.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipo_pkg.sv
// -----------------------------------------------------------------------------
// pipo_pkg
// Shared constants for the parallel-in / parallel-out register.
//   PIPO_DEFAULT_WIDTH        default data-path width
//   PIPO_MAX_WIDTH            widest legal data path; also the width of the
//                             RESET_VALUE parameter so it can be range-checked
//   PIPO_DEFAULT_RESET_VALUE  default register contents after reset (all zeros)
// -----------------------------------------------------------------------------
package pipo_pkg;

    localparam int PIPO_DEFAULT_WIDTH = 4;
    localparam int PIPO_MAX_WIDTH     = 64;

    localparam logic [PIPO_MAX_WIDTH-1:0] PIPO_DEFAULT_RESET_VALUE = '0;

endpackage : pipo_pkg

// File: rtl/pipo.sv
// -----------------------------------------------------------------------------
// pipo
// WIDTH-bit parallel-in / parallel-out register with synchronous reset and a
// load enable. Priority at each rising edge: reset > load > hold.
//
// Parameters
//   WIDTH        data-path width, 1..64
//   RESET_VALUE  register contents after reset; carried at the maximum width
//                so that a value too wide for WIDTH is caught at elaboration
//
// Ports
//   i_clk           clock, all state changes on its rising edge
//   i_rst           synchronous active-high reset
//   i_load          1 = capture i_parallel_in at the next rising edge
//   i_parallel_in   data to capture
//   o_parallel_out  register contents, driven straight from the flops
// -----------------------------------------------------------------------------
module pipo
    import pipo_pkg::*;
#(
    parameter int                         WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter logic [PIPO_MAX_WIDTH-1:0]  RESET_VALUE = PIPO_DEFAULT_RESET_VALUE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_parallel_in,
    output logic [WIDTH-1:0] o_parallel_out
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > PIPO_MAX_WIDTH) begin : g_bad_width
        $error("pipo: WIDTH=%0d outside legal range 1..%0d", WIDTH, PIPO_MAX_WIDTH);
    end

    // Any set bit above WIDTH would be silently dropped by the slice below.
    if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_reset_value
        $error("pipo: RESET_VALUE does not fit in WIDTH=%0d bits", WIDTH);
    end

    localparam logic [WIDTH-1:0] RESET_WORD = RESET_VALUE[WIDTH-1:0];

    // ------------------------------------------------------------------
    // The register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_reg <= RESET_WORD;
        end else if (i_load) begin
            data_reg <= i_parallel_in;
        end
    end

    assign o_parallel_out = data_reg;

`ifndef SYNTHESIS
    // ------------------------------------------------------------------
    // Embedded checks: what each edge did must be visible at the next one.
    // Nothing is checked until a reset edge has been seen, since the
    // register has no defined power-on value.
    // ------------------------------------------------------------------
    logic             seen_rst_reg;
    logic             past_rst_reg;
    logic             past_load_reg;
    logic [WIDTH-1:0] past_in_reg;
    logic [WIDTH-1:0] past_out_reg;

    always_ff @(posedge i_clk) begin
        seen_rst_reg  <= (seen_rst_reg === 1'b1) || i_rst;
        past_rst_reg  <= i_rst;
        past_load_reg <= i_load;
        past_in_reg   <= i_parallel_in;
        past_out_reg  <= o_parallel_out;
    end

    always @(posedge i_clk) begin
        if (seen_rst_reg === 1'b1) begin
            if (past_rst_reg) begin
                assert (o_parallel_out == RESET_WORD)
                    else $error("pipo: reset edge did not yield RESET_VALUE");
            end else if (past_load_reg) begin
                assert (o_parallel_out == past_in_reg)
                    else $error("pipo: load edge did not capture input");
            end else begin
                assert (o_parallel_out == past_out_reg)
                    else $error("pipo: hold edge changed the register");
            end
        end
    end
`endif

endmodule : pipo

// File: tb/tb_pipo.sv
// -----------------------------------------------------------------------------
// tb_pipo
// Self-checking bench for pipo. Two instances share one clock: a default
// 4-bit one (zero reset value) and a 16-bit one with a non-zero reset value.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit after the edge that should have updated them.
// -----------------------------------------------------------------------------
module tb_pipo;

    localparam logic [15:0] RV16 = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst4 = 1'b0, load4 = 1'b0;
    logic [3:0]  in4 = '0;
    logic [3:0]  out4;
    logic        rst16 = 1'b0, load16 = 1'b0;
    logic [15:0] in16 = '0;
    logic [15:0] out16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipo dut4 (
        .i_clk          (clk),
        .i_rst          (rst4),
        .i_load         (load4),
        .i_parallel_in  (in4),
        .o_parallel_out (out4)
    );

    pipo #(.WIDTH(16), .RESET_VALUE(64'(RV16))) dut16 (
        .i_clk          (clk),
        .i_rst          (rst16),
        .i_load         (load16),
        .i_parallel_in  (in16),
        .o_parallel_out (out16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; load4 = 1'b0; in4 = 4'b1010;
        rst16 = 1'b1; load16 = 1'b0; in16 = 16'h1234;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (out4 !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset4 edge%0d: got %b expected 0000", k, out4);
            end
            n_checks++;
            if (out16 !== RV16) begin
                n_fail++;
                $display("FAIL reset16 edge%0d: got %h expected %h", k, out16, RV16);
            end
        end
        $display("test_reset: out4=%b out16=%h", out4, out16);
        rst16 = 1'b0;
    endtask

    task automatic test_load_latency();
        rst4 = 1'b0; load4 = 1'b1; in4 = 4'b1010;
        #2;
        n_checks++;
        if (out4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL load_early: got %b expected 0000 before edge", out4);
        end
        tick();
        n_checks++;
        if (out4 !== 4'b1010) begin
            n_fail++;
            $display("FAIL load_latency: got %b expected 1010", out4);
        end
        $display("test_load_latency: out4=%b", out4);
    endtask

    task automatic test_hold();
        load4 = 1'b0; in4 = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #2 in4 = (k[0]) ? 4'b1111 : 4'b0101;   // wiggle between edges
            tick();
            n_checks++;
            if (out4 !== 4'b1010) begin
                n_fail++;
                $display("FAIL hold edge%0d: got %b expected 1010", k, out4);
            end
        end
        $display("test_hold: out4=%b", out4);
    endtask

    task automatic test_reload();
        load4 = 1'b1; in4 = 4'b0101;
        tick();
        n_checks++;
        if (out4 !== 4'b0101) begin
            n_fail++;
            $display("FAIL reload: got %b expected 0101", out4);
        end
        $display("test_reload: out4=%b", out4);
    endtask

    task automatic test_sync_reset_pulse();
        // Pulse between edges must not touch the output.
        load4 = 1'b0;
        #2 rst4 = 1'b1;
        #2;
        n_checks++;
        if (out4 !== 4'b0101) begin
            n_fail++;
            $display("FAIL rst_pulse_mid: got %b expected 0101", out4);
        end
        rst4 = 1'b0;
        tick();
        n_checks++;
        if (out4 !== 4'b0101) begin
            n_fail++;
            $display("FAIL rst_pulse_after: got %b expected 0101", out4);
        end
        $display("test_sync_reset_pulse: out4=%b", out4);
    endtask

    task automatic test_priority();
        rst4 = 1'b1; load4 = 1'b1; in4 = 4'b1111;
        tick();
        n_checks++;
        if (out4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL priority: got %b expected 0000", out4);
        end
        // First load after reset must take effect immediately.
        rst4 = 1'b0; load4 = 1'b1; in4 = 4'b0110;
        tick();
        n_checks++;
        if (out4 !== 4'b0110) begin
            n_fail++;
            $display("FAIL post_reset_load: got %b expected 0110", out4);
        end
        $display("test_priority: out4=%b", out4);
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        load16 = 1'b1; rst16 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            v = 16'h1111 * 16'(k + 1) ^ 16'h8001;
            in16 = v;
            tick();
            n_checks++;
            if (out16 !== v) begin
                n_fail++;
                $display("FAIL b2b16 k%0d: got %h expected %h", k, out16, v);
            end
        end
        load16 = 1'b0;
        $display("test_back_to_back: out16=%h", out16);
    endtask

    // Reference: output is the reset value if the most recent qualifying
    // event was a reset, otherwise the last value presented with load high.
    task automatic test_random();
        logic [3:0]  exp4;
        logic [15:0] exp16;
        int          bad = 0;
        exp4  = out4 === 4'b0110 ? 4'b0110 : 4'bx;
        exp16 = out16 === 16'h7778 ? 16'h7778 : 16'hxxxx;
        // Start from a known state on both instances.
        rst4 = 1'b1; rst16 = 1'b1;
        tick();
        exp4 = 4'b0000; exp16 = RV16;
        for (int c = 0; c < 1000; c++) begin
            rst4   = ($urandom_range(0, 15) == 0);
            load4  = $urandom_range(0, 1) == 1;
            in4    = 4'($urandom);
            rst16  = ($urandom_range(0, 15) == 0);
            load16 = $urandom_range(0, 1) == 1;
            in16   = 16'($urandom);
            if (rst4) exp4 = 4'b0000; else if (load4) exp4 = in4;
            if (rst16) exp16 = RV16;  else if (load16) exp16 = in16;
            tick();
            n_checks++;
            if (out4 !== exp4) begin
                n_fail++; bad++;
                $display("FAIL rand4 c%0d: got %b expected %b", c, out4, exp4);
            end
            n_checks++;
            if (out16 !== exp16) begin
                n_fail++; bad++;
                $display("FAIL rand16 c%0d: got %h expected %h", c, out16, exp16);
            end
        end
        rst4 = 1'b0; load4 = 1'b0; rst16 = 1'b0; load16 = 1'b0;
        $display("test_random: 1000 cycles, %0d bad", bad);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_load_latency();
        test_hold();
        test_reload();
        test_sync_reset_pulse();
        test_priority();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipo
